lfsr_sync_checker: RTL

Receive-side companion to the 16-bit PRBS generator. It self-synchronises to an incoming serial stream produced by the x^16+x^14+x^13+x^11+1 Fibonacci LFSR (taps at register bits 15, 13, 12 and 10, MSB-out, left shift). Once locked, it flywheels a local copy of the sequence and counts bit errors. It sits at the far end of a link or loopback under test and feeds lock and BER status to software.

---
 rtl/lfsr_pkg.sv | 10 +
 rtl/lfsr_err_window.sv | 35 +++
 rtl/lfsr_sync_checker.sv | 101 ++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared PRBS16 constants, state encoding and feedback helper
package lfsr_pkg;
    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'h0001;
    typedef enum logic [1:0] {FILL = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_e;
    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] sr);
        return ^(sr & LFSR_TAPS);
    endfunction
endpackage

// File: rtl/lfsr_err_window.sv
// lfsr_err_window: counts errors per fixed-length window and trips at threshold
module lfsr_err_window #(
    parameter int ERR_WIN    = 256,
    parameter int ERR_THRESH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic valid,
    input  logic err,
    output logic trip
);
    localparam int WW = $clog2(ERR_WIN);
    localparam int TW = $clog2(ERR_THRESH + 1);
    logic [WW-1:0] win_q, win_d;
    logic [TW-1:0] errs_q, errs_d;
    logic wrap;
    assign wrap = win_q == WW'(ERR_WIN - 1);
    assign win_d = wrap ? '0 : win_q + WW'(1);
    // an error on the wrapping bit belongs to the new window
    assign errs_d = (wrap ? '0 : errs_q) + TW'(err);
    assign trip = valid && err && errs_d == TW'(ERR_THRESH);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q  <= '0;
            errs_q <= '0;
        end else if (start) begin
            win_q  <= '0;
            errs_q <= '0;
        end else if (valid) begin
            win_q  <= win_d;
            errs_q <= errs_d;
        end
    end
endmodule

// File: rtl/lfsr_sync_checker.sv
// lfsr_sync_checker: self-synchronising PRBS16 receiver with flywheel and BER counters
module lfsr_sync_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT   = 32,
    parameter int ERR_WIN    = 256,
    parameter int ERR_THRESH = 8,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear,
    output logic             locked,
    output logic [1:0]       state,
    output logic             err_pulse,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int RUN_W = $clog2(LOCK_CNT + 1);
    state_e state_q, state_d;
    logic [LFSR_W-1:0] sr_q, sr_d;
    logic [3:0] fill_q, fill_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d, err_cnt_q, err_cnt_d;
    logic locked_q, err_pulse_q, err_pulse_d;
    logic pred, mis, chk, start, trip;
    assign pred = lfsr_fb(sr_q);
    assign mis = in_bit ^ pred;
    assign chk = in_valid && state_q == LOCKED;
    // once locked the register flywheels on its own prediction
    assign sr_d = in_valid ? {sr_q[LFSR_W-2:0], state_q == LOCKED ? pred : in_bit} : sr_q;
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        run_d   = run_q;
        start   = 1'b0;
        if (in_valid) begin
            case (state_q)
                FILL: begin
                    fill_d = fill_q + 4'd1;
                    if (fill_q == 4'd15) begin
                        state_d = ACQUIRE;
                        run_d   = '0;
                    end
                end
                ACQUIRE: begin
                    run_d = (mis || sr_d == '0) ? '0 : run_q + RUN_W'(1);
                    if (run_d == RUN_W'(LOCK_CNT)) begin
                        state_d = LOCKED;
                        start   = 1'b1;
                    end
                end
                default: begin
                    if (trip) begin
                        state_d = FILL;
                        fill_d  = '0;
                    end
                end
            endcase
        end
    end
    assign bit_cnt_d = clear ? '0 : (chk && ~&bit_cnt_q) ? bit_cnt_q + CNT_W'(1) : bit_cnt_q;
    assign err_cnt_d = clear ? '0 : (chk && mis && ~&err_cnt_q) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
    assign err_pulse_d = chk && mis;
    lfsr_err_window #(.ERR_WIN(ERR_WIN), .ERR_THRESH(ERR_THRESH)) u_win (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .valid(chk),
        .err  (mis),
        .trip (trip)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            sr_q        <= '0;
            fill_q      <= '0;
            run_q       <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            bit_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            run_q       <= run_d;
            locked_q    <= state_d == LOCKED;
            err_pulse_q <= err_pulse_d;
            bit_cnt_q   <= bit_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end
    assign locked    = locked_q;
    assign state     = state_q;
    assign err_pulse = err_pulse_q;
    assign bit_cnt   = bit_cnt_q;
    assign err_cnt   = err_cnt_q;
endmodule
